// File: rtl/aes_round_key_store.sv
// Round-key store: subkey bytes stream in linearly and are served by (round, byte)
// in encrypt or reversed-round order, plus a fixed-latency delayed copy of each read.
module aes_round_key_store #(
  parameter int DATA_W          = 8,
  parameter int NUM_ROUNDS      = 11,
  parameter int BYTES_PER_ROUND = 16,
  parameter int DELAY           = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  clear,
  input  logic                                                  wr_valid,
  output logic                                                  wr_ready,
  input  logic [DATA_W-1:0]                                     wr_data,
  input  logic                                                  rd_en,
  input  logic                                                  rd_decrypt,
  input  logic [$clog2(NUM_ROUNDS)-1:0]                         rd_round,
  input  logic [$clog2(BYTES_PER_ROUND)-1:0]                    rd_byte,
  output logic [DATA_W-1:0]                                     rd_data,
  output logic                                                  rd_hit,
  output logic [DATA_W-1:0]                                     rd_data_dly,
  output logic                                                  rd_valid_dly,
  output logic [$clog2(NUM_ROUNDS*BYTES_PER_ROUND):0]           fill_count,
  output logic                                                  keys_ready
);

  localparam int DEPTH = NUM_ROUNDS * BYTES_PER_ROUND;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(NUM_ROUNDS);
  localparam int BW    = $clog2(BYTES_PER_ROUND);

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [AW:0]           fill_count_q, fill_count_d;
  logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [RW-1:0]         round_cnt_q, round_cnt_d;
  logic [NUM_ROUNDS-1:0] round_valid_q, round_valid_d;
  logic                  keys_ready_q, keys_ready_d;
  logic [AW-1:0]         wr_ptr;
  logic                  wr_fire;

  // Handshake: a byte moves on a rising edge with wr_valid & wr_ready; wr_data must be
  // stable while wr_valid is high. Clear and reset take precedence and drop that byte.
  assign wr_ready = ~keys_ready_q;
  assign wr_fire  = wr_valid & wr_ready & ~clear & rst_n;
  assign wr_ptr   = fill_count_q[AW-1:0];

  always_comb begin
    fill_count_d  = fill_count_q;
    byte_cnt_d    = byte_cnt_q;
    round_cnt_d   = round_cnt_q;
    round_valid_d = round_valid_q;
    keys_ready_d  = keys_ready_q;
    if (clear) begin
      fill_count_d  = '0;
      byte_cnt_d    = '0;
      round_cnt_d   = '0;
      round_valid_d = '0;
      keys_ready_d  = 1'b0;
    end else if (wr_fire) begin
      fill_count_d = fill_count_q + (AW+1)'(1);
      if (byte_cnt_q == BW'(BYTES_PER_ROUND - 1)) begin
        byte_cnt_d                 = '0;
        round_valid_d[round_cnt_q] = 1'b1;
        // The round counter parks on the last round; the pointer never wraps.
        if (round_cnt_q == RW'(NUM_ROUNDS - 1)) begin
          keys_ready_d = 1'b1;
        end else begin
          round_cnt_d = round_cnt_q + RW'(1);
        end
      end else begin
        byte_cnt_d = byte_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_count_q  <= '0;
      byte_cnt_q    <= '0;
      round_cnt_q   <= '0;
      round_valid_q <= '0;
      keys_ready_q  <= 1'b0;
    end else begin
      fill_count_q  <= fill_count_d;
      byte_cnt_q    <= byte_cnt_d;
      round_cnt_q   <= round_cnt_d;
      round_valid_q <= round_valid_d;
      keys_ready_q  <= keys_ready_d;
    end
  end

  // Key memory is deliberately not reset; completion flags gate its use.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr] <= wr_data;
    end
  end

  logic          rd_in_range;
  logic [RW-1:0] rd_phys;
  logic [AW-1:0] rd_addr;

  assign rd_in_range = ({1'b0, rd_round} < (RW+1)'(NUM_ROUNDS)) &&
                       ({1'b0, rd_byte} < (BW+1)'(BYTES_PER_ROUND));
  assign rd_phys     = rd_decrypt ? (RW'(NUM_ROUNDS - 1) - rd_round) : rd_round;
  assign rd_addr     = AW'(rd_phys) * AW'(BYTES_PER_ROUND) + AW'(rd_byte);

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    if (rd_en && rd_in_range) begin
      rd_data = mem_q[rd_addr];
      rd_hit  = round_valid_q[rd_phys];
    end
  end

  logic                  rd_take;
  logic [DELAY-1:0]      dly_valid_q;
  logic [DATA_W-1:0]     dly_data_q [DELAY];

  assign rd_take = rd_en & rd_hit;

  // Free-running alignment pipe; clear leaves it alone, only reset flushes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        dly_valid_q[i] <= 1'b0;
        dly_data_q[i]  <= '0;
      end
    end else begin
      dly_valid_q[0] <= rd_take;
      dly_data_q[0]  <= rd_take ? rd_data : '0;
      for (int i = 1; i < DELAY; i++) begin
        dly_valid_q[i] <= dly_valid_q[i-1];
        dly_data_q[i]  <= dly_data_q[i-1];
      end
    end
  end

  assign rd_valid_dly = dly_valid_q[DELAY-1];
  assign rd_data_dly  = dly_data_q[DELAY-1];
  assign fill_count   = fill_count_q;
  assign keys_ready   = keys_ready_q;

endmodule

// File: tb/tb_aes_round_key_store.sv
// Bench for aes_round_key_store: default instance checked every cycle against an
// array/queue model, plus a NUM_ROUNDS=15, DELAY=1 instance with directed checks.
module tb_aes_round_key_store;

  localparam int NR    = 11;
  localparam int BPR   = 16;
  localparam int D     = 4;
  localparam int DEPTH = NR * BPR;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear, wr_valid, wr_ready, rd_en, rd_decrypt, rd_hit, rd_valid_dly, keys_ready;
  logic [7:0] wr_data, rd_data, rd_data_dly;
  logic [3:0] rd_round, rd_byte;
  logic [8:0] fill_count;

  logic       rst2_n, clear2, wr_valid2, wr_ready2, rd_en2, rd_decrypt2, rd_hit2, rd_valid_dly2, keys_ready2;
  logic [7:0] wr_data2, rd_data2, rd_data_dly2;
  logic [3:0] rd_round2, rd_byte2;
  logic [8:0] fill_count2;

  aes_round_key_store dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_en(rd_en), .rd_decrypt(rd_decrypt), .rd_round(rd_round), .rd_byte(rd_byte),
    .rd_data(rd_data), .rd_hit(rd_hit), .rd_data_dly(rd_data_dly), .rd_valid_dly(rd_valid_dly),
    .fill_count(fill_count), .keys_ready(keys_ready)
  );

  aes_round_key_store #(.NUM_ROUNDS(15), .DELAY(1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .clear(clear2),
    .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_data(wr_data2),
    .rd_en(rd_en2), .rd_decrypt(rd_decrypt2), .rd_round(rd_round2), .rd_byte(rd_byte2),
    .rd_data(rd_data2), .rd_hit(rd_hit2), .rd_data_dly(rd_data_dly2), .rd_valid_dly(rd_valid_dly2),
    .fill_count(fill_count2), .keys_ready(keys_ready2)
  );

  // Reference model: byte array in load order, count of bytes loaded, delay pipe as a queue.
  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  int         m_fill;
  logic [8:0] dq[$];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_fill = 0;
    dq = {};
    for (int i = 0; i < D; i++) dq.push_back(9'h0);
  endtask

  function automatic void model_read(output bit hit, output logic [7:0] data, output bit known);
    int p, a;
    hit = 0; data = 8'h00; known = 1;
    if (rd_en && int'(rd_round) < NR) begin
      p     = rd_decrypt ? NR - 1 - int'(rd_round) : int'(rd_round);
      a     = p * BPR + int'(rd_byte);
      hit   = (m_fill >= (p + 1) * BPR);
      data  = m_mem[a];
      known = m_known[a];
    end
  endfunction

  // One clock cycle: check combinational/status outputs before the edge, update model, check delay pipe.
  task automatic tick();
    bit h, k;
    logic [7:0] d;
    logic [8:0] stage;
    #1;
    model_read(h, d, k);
    chk("rd_hit", rd_hit, h);
    if (k) chk("rd_data", rd_data, d);
    chk("fill_count", fill_count, m_fill);
    chk("keys_ready", keys_ready, m_fill == DEPTH);
    chk("wr_ready", wr_ready, m_fill != DEPTH);
    stage = {h, h ? d : 8'h00};
    @(posedge clk); #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      dq.push_back(stage);
      void'(dq.pop_front());
      if (clear) m_fill = 0;
      else if (wr_valid && m_fill < DEPTH) begin
        m_mem[m_fill]   = wr_data;
        m_known[m_fill] = 1;
        m_fill++;
      end
    end
    chk("rd_valid_dly", rd_valid_dly, dq[0][8]);
    chk("rd_data_dly", rd_data_dly, dq[0][7:0]);
  endtask

  task automatic rd_set(input bit en, input bit dec, input int r, input int b);
    rd_en = en; rd_decrypt = dec; rd_round = 4'(r); rd_byte = 4'(b);
    #1;
  endtask

  task automatic rand_read();
    rd_en      = 1'($urandom_range(0, 1));
    rd_decrypt = 1'($urandom_range(0, 1));
    rd_round   = 4'($urandom_range(0, 15));
    rd_byte    = 4'($urandom_range(0, 15));
  endtask

  // Offer n bytes (pattern = running byte index, or random), optionally with idle gaps.
  task automatic load(input int n, input bit rand_data, input bit gaps);
    int i = 0;
    while (i < n) begin
      wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = rand_data ? 8'($urandom) : 8'(m_fill);
      rand_read();
      tick();
      if (wr_valid) i++;
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] saved;
    rst_n = 0; clear = 0; wr_valid = 0; wr_data = 0;
    rd_en = 0; rd_decrypt = 0; rd_round = 0; rd_byte = 0;
    rst2_n = 0; clear2 = 0; wr_valid2 = 0; wr_data2 = 0;
    rd_en2 = 0; rd_decrypt2 = 0; rd_round2 = 0; rd_byte2 = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;
    rd_set(1, 0, 0, 0);
    chk("reset fill_count", fill_count, 0);
    chk("reset keys_ready", keys_ready, 0);
    chk("reset wr_ready", wr_ready, 1);
    chk("reset rd_hit", rd_hit, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset rd_valid_dly", rd_valid_dly, 0);
    chk("reset rd_data_dly", rd_data_dly, 0);

    // Full load 0x00..0xAF with wr_valid held high.
    load(DEPTH, 0, 0);
    chk("full fill_count", fill_count, 176);
    chk("full keys_ready", keys_ready, 1);
    rd_set(1, 0, 3, 5);
    chk("r3b5 data", rd_data, 8'h35);
    chk("r3b5 hit", rd_hit, 1);

    // Backpressure after full.
    wr_valid = 1; wr_data = 8'hFF;
    repeat (5) tick();
    wr_valid = 0;
    chk("bp wr_ready", wr_ready, 0);
    chk("bp fill_count", fill_count, 176);
    rd_set(1, 0, 10, 15);
    chk("r10b15 data", rd_data, 8'hAF);

    // Decrypt mapping.
    rd_set(1, 1, 0, 0);
    chk("dec r0 data", rd_data, 8'hA0);
    rd_set(1, 1, 10, 0);
    chk("dec r10 data", rd_data, 8'h00);
    rd_set(1, 0, 11, 0);
    chk("oob r11 hit", rd_hit, 0);
    chk("oob r11 data", rd_data, 0);

    repeat (30) begin rand_read(); tick(); end

    // Partial load and delayed read.
    rd_set(0, 0, 0, 0);
    clear = 1; tick(); clear = 0;
    load(20, 1, 0);
    rd_set(1, 0, 0, 7);
    chk("partial r0 hit", rd_hit, 1);
    saved = m_mem[7];
    tick();
    rd_en = 0;
    repeat (2) tick();
    chk("dly early valid", rd_valid_dly, 0);
    tick();
    chk("dly valid", rd_valid_dly, 1);
    chk("dly data", rd_data_dly, saved);
    rd_set(1, 0, 1, 0);
    chk("partial r1 hit", rd_hit, 0);
    tick();
    rd_en = 0;
    repeat (3) tick();
    chk("r1 dly valid", rd_valid_dly, 0);

    // Clear together with a write transfer mid-load.
    load(20, 1, 0);
    saved = m_mem[1];
    wr_valid = 1; wr_data = 8'h5A; clear = 1;
    tick();
    clear = 0; wr_valid = 0;
    chk("clear fill_count", fill_count, 0);
    rd_set(1, 0, 0, 0);
    chk("clear r0 hit", rd_hit, 0);
    wr_valid = 1; wr_data = 8'hC3;
    tick();
    wr_valid = 0;
    rd_set(1, 0, 0, 0);
    chk("post-clear addr0", rd_data, 8'hC3);
    chk("post-clear fill", fill_count, 1);
    rd_set(1, 0, 0, 1);
    chk("post-clear addr1 kept", rd_data, saved);

    // Reset mid-load with reads in flight.
    load(30, 1, 1);
    rd_set(1, 0, 0, 3);
    repeat (2) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst rd_valid_dly", rd_valid_dly, 0);
    chk("rst rd_data_dly", rd_data_dly, 0);
    chk("rst fill_count", fill_count, 0);
    rd_set(1, 0, 0, 3);
    chk("rst r0 hit", rd_hit, 0);

    // Random full load with gaps, then random reads.
    load(DEPTH, 1, 1);
    repeat (40) begin rand_read(); tick(); end
    rd_en = 0;

    // NUM_ROUNDS=15, DELAY=1 instance.
    @(posedge clk); #1;
    rst2_n = 1;
    for (int i = 0; i < 239; i++) begin
      wr_valid2 = 1; wr_data2 = 8'(i);
      @(posedge clk); #1;
    end
    chk("p2 keys_ready early", keys_ready2, 0);
    chk("p2 fill 239", fill_count2, 239);
    wr_data2 = 8'hEF;
    @(posedge clk); #1;
    wr_valid2 = 0;
    chk("p2 keys_ready", keys_ready2, 1);
    chk("p2 fill 240", fill_count2, 240);
    chk("p2 wr_ready", wr_ready2, 0);
    rd_en2 = 1; rd_round2 = 4'd15; rd_byte2 = 4'd0; #1;
    chk("p2 r15 hit", rd_hit2, 0);
    chk("p2 r15 data", rd_data2, 0);
    rd_decrypt2 = 1; rd_round2 = 4'd0; #1;
    chk("p2 dec r0 data", rd_data2, 8'hE0);
    rd_decrypt2 = 0; rd_round2 = 4'd14; rd_byte2 = 4'd15; #1;
    chk("p2 r14b15 data", rd_data2, 8'hEF);
    chk("p2 pre-edge dly", rd_valid_dly2, 0);
    @(posedge clk); #1;
    rd_en2 = 0;
    chk("p2 dly valid", rd_valid_dly2, 1);
    chk("p2 dly data", rd_data_dly2, 8'hEF);
    @(posedge clk); #1;
    chk("p2 dly drop valid", rd_valid_dly2, 0);
    chk("p2 dly drop data", rd_data_dly2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
